// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared types and defaults for the video RAM arbiter
package vga_pkg;

    localparam int AW_DEFAULT = 16;
    localparam int DW_DEFAULT = 8;
    localparam int WW_DEFAULT = 8;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_PENDING = 2'd1,
        ARB_DONE    = 2'd2
    } arb_state_e;

endpackage

// File: rtl/vga_mem_arbiter.sv
// rtl/vga_mem_arbiter.sv - video RAM arbiter: VGA fetcher has absolute priority, CPU requests
// are latched, issued in the next free cycle and acknowledged with a one-cycle pulse.
module vga_mem_arbiter
    import vga_pkg::*;
#(
    parameter int AW = AW_DEFAULT,
    parameter int DW = DW_DEFAULT,
    parameter int WW = WW_DEFAULT
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic [AW-1:0] i_cpu_addr,
    input  logic [DW-1:0] i_cpu_dat,
    input  logic          i_cpu_we,
    input  logic          i_cpu_cs,
    output logic [DW-1:0] o_cpu_dat,
    output logic          o_cpu_ack,
    output logic          o_cpu_busy,
    input  logic          i_vga_access,
    input  logic [AW-1:0] i_vga_addr,
    input  logic          i_vga_cs,
    output logic [DW-1:0] o_vga_dat,
    output logic [AW-1:0] o_ram_addr,
    output logic [DW-1:0] o_ram_dat,
    output logic          o_ram_cs,
    output logic          o_ram_we,
    input  logic [DW-1:0] i_ram_dat,
    output logic          o_vga_err,
    output logic [WW-1:0] o_max_wait
);

    arb_state_e    state_q, state_d;
    logic          vga_slot_q, vga_slot_d;
    logic [AW-1:0] hold_addr_q, hold_addr_d;
    logic [DW-1:0] hold_dat_q, hold_dat_d;
    logic          hold_we_q, hold_we_d;
    logic [DW-1:0] cpu_dat_q, cpu_dat_d;
    logic          vga_err_q, vga_err_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [WW-1:0] max_wait_q, max_wait_d;

    logic vga_owns;
    logic accept;
    logic issue;

    assign vga_owns = vga_slot_q | i_vga_cs;
    assign accept   = (state_q == ARB_IDLE) & i_cpu_cs;
    assign issue    = (state_q == ARB_PENDING) & ~vga_owns;

    always_ff @(posedge i_clk) begin
        state_q     <= state_d;
        vga_slot_q  <= vga_slot_d;
        hold_addr_q <= hold_addr_d;
        hold_dat_q  <= hold_dat_d;
        hold_we_q   <= hold_we_d;
        cpu_dat_q   <= cpu_dat_d;
        vga_err_q   <= vga_err_d;
        wait_q      <= wait_d;
        max_wait_q  <= max_wait_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE:    if (i_cpu_cs) state_d = ARB_PENDING;
            ARB_PENDING: if (!vga_owns) state_d = ARB_DONE;
            ARB_DONE:    state_d = ARB_IDLE;
            default:     state_d = ARB_IDLE;
        endcase
        if (i_reset) state_d = ARB_IDLE;
    end

    // Hold registers, statistics and the captured read data.
    always_comb begin
        vga_slot_d  = i_vga_access;
        hold_addr_d = hold_addr_q;
        hold_dat_d  = hold_dat_q;
        hold_we_d   = hold_we_q;
        cpu_dat_d   = cpu_dat_q;
        vga_err_d   = vga_err_q | (i_vga_cs & ~vga_slot_q);
        wait_d      = wait_q;
        max_wait_d  = max_wait_q;

        if (accept) begin
            hold_addr_d = i_cpu_addr;
            hold_dat_d  = i_cpu_dat;
            hold_we_d   = i_cpu_we;
            wait_d      = '0;
        end else if ((state_q == ARB_PENDING) && vga_owns) begin
            if (wait_q != {WW{1'b1}}) wait_d = wait_q + 1'b1;
        end else if (issue) begin
            if (!hold_we_q) cpu_dat_d = i_ram_dat;
            if (wait_q > max_wait_q) max_wait_d = wait_q;
        end

        if (i_reset) begin
            vga_slot_d  = 1'b0;
            hold_addr_d = '0;
            hold_dat_d  = '0;
            hold_we_d   = 1'b0;
            cpu_dat_d   = '0;
            vga_err_d   = 1'b0;
            wait_d      = '0;
            max_wait_d  = '0;
        end
    end

    // RAM bus mux; reset forces every strobe low so a queued write cannot land.
    always_comb begin
        o_ram_addr = '0;
        o_ram_dat  = '0;
        o_ram_cs   = 1'b0;
        o_ram_we   = 1'b0;
        o_cpu_ack  = 1'b0;
        o_cpu_busy = 1'b0;
        if (!i_reset) begin
            if (vga_owns) begin
                o_ram_addr = i_vga_addr;
                o_ram_cs   = i_vga_cs;
            end else if (state_q == ARB_PENDING) begin
                o_ram_addr = hold_addr_q;
                o_ram_dat  = hold_dat_q;
                o_ram_cs   = 1'b1;
                o_ram_we   = hold_we_q;
            end
            o_cpu_ack  = (state_q == ARB_DONE);
            o_cpu_busy = (state_q != ARB_IDLE);
        end
    end

    assign o_cpu_dat  = cpu_dat_q;
    assign o_vga_dat  = i_ram_dat;
    assign o_vga_err  = vga_err_q;
    assign o_max_wait = max_wait_q;

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// tb/tb_vga_mem_arbiter.sv - self-checking bench for vga_mem_arbiter
module tb_vga_mem_arbiter;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [15:0] i_cpu_addr;
    logic [7:0]  i_cpu_dat;
    logic        i_cpu_we;
    logic        i_cpu_cs;
    logic [7:0]  o_cpu_dat;
    logic        o_cpu_ack;
    logic        o_cpu_busy;
    logic        i_vga_access;
    logic [15:0] i_vga_addr;
    logic        i_vga_cs;
    logic [7:0]  o_vga_dat;
    logic [15:0] o_ram_addr;
    logic [7:0]  o_ram_dat;
    logic        o_ram_cs;
    logic        o_ram_we;
    logic [7:0]  i_ram_dat;
    logic        o_vga_err;
    logic [7:0]  o_max_wait;

    always #5 i_clk = ~i_clk;

    vga_mem_arbiter dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_cpu_addr(i_cpu_addr), .i_cpu_dat(i_cpu_dat), .i_cpu_we(i_cpu_we), .i_cpu_cs(i_cpu_cs),
        .o_cpu_dat(o_cpu_dat), .o_cpu_ack(o_cpu_ack), .o_cpu_busy(o_cpu_busy),
        .i_vga_access(i_vga_access), .i_vga_addr(i_vga_addr), .i_vga_cs(i_vga_cs),
        .o_vga_dat(o_vga_dat),
        .o_ram_addr(o_ram_addr), .o_ram_dat(o_ram_dat), .o_ram_cs(o_ram_cs), .o_ram_we(o_ram_we),
        .i_ram_dat(i_ram_dat),
        .o_vga_err(o_vga_err), .o_max_wait(o_max_wait)
    );

    // Video RAM: asynchronous read, write at the clock edge.
    logic [7:0] mem [0:65535];
    assign i_ram_dat = mem[o_ram_addr];
    always @(posedge i_clk) if (o_ram_cs && o_ram_we) mem[o_ram_addr] <= o_ram_dat;

    int checks = 0;
    int failures = 0;
    int dut_acks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Transaction-level model: one outstanding CPU request walking through
    // phase 0 (none), 1 (waiting for a free bus), 2 (acknowledging).
    logic [7:0]  shadow [0:65535];
    bit          m_valid = 0;
    int          m_phase = 0;
    logic [15:0] m_addr = '0;
    logic [7:0]  m_dat = '0;
    logic        m_we = 1'b0;
    int          m_wait = 0;
    int          m_max = 0;
    logic [7:0]  m_cpu_dat = '0;
    bit          m_err = 0;
    bit          m_slot = 0;
    int          m_accepts = 0;

    always @(posedge i_clk) begin
        if (i_reset) begin
            m_valid = 1; m_phase = 0; m_wait = 0; m_max = 0;
            m_cpu_dat = '0; m_err = 0; m_slot = 0;
        end else if (m_valid) begin
            if (i_vga_cs && !m_slot) m_err = 1;
            if (m_phase == 0) begin
                if (i_cpu_cs) begin
                    m_addr = i_cpu_addr; m_dat = i_cpu_dat; m_we = i_cpu_we;
                    m_wait = 0; m_phase = 1; m_accepts++;
                end
            end else if (m_phase == 1) begin
                if (m_slot || i_vga_cs) begin
                    m_wait = (m_wait >= 255) ? 255 : m_wait + 1;
                end else begin
                    if (m_we) shadow[m_addr] = m_dat;
                    else m_cpu_dat = shadow[m_addr];
                    m_max = (m_wait > m_max) ? m_wait : m_max;
                    m_phase = 2;
                end
            end else begin
                m_phase = 0;
            end
            m_slot = i_vga_access;
        end
    end

    always @(negedge i_clk) begin
        logic [15:0] e_addr;
        logic [7:0]  e_dat;
        logic        e_cs, e_we;
        if (m_valid) begin
            e_addr = '0; e_dat = '0; e_cs = 0; e_we = 0;
            if (!i_reset) begin
                if (m_slot || i_vga_cs) begin
                    e_addr = i_vga_addr; e_cs = i_vga_cs;
                end else if (m_phase == 1) begin
                    e_addr = m_addr; e_dat = m_dat; e_cs = 1; e_we = m_we;
                end
            end
            chk("ram_addr", o_ram_addr, e_addr);
            chk("ram_dat", o_ram_dat, e_dat);
            chk("ram_cs", o_ram_cs, e_cs);
            chk("ram_we", o_ram_we, e_we);
            chk("cpu_ack", o_cpu_ack, !i_reset && m_phase == 2);
            chk("cpu_busy", o_cpu_busy, !i_reset && m_phase != 0);
            chk("cpu_dat", o_cpu_dat, m_cpu_dat);
            chk("vga_err", o_vga_err, m_err);
            chk("max_wait", o_max_wait, m_max);
            chk("vga_dat", o_vga_dat, mem[o_ram_addr]);
            if (o_cpu_ack) dut_acks++;
        end
    end

    task automatic next_cycle();
        @(posedge i_clk); #1;
    endtask

    task automatic mid_cycle();
        @(negedge i_clk); #1;
    endtask

    int acks_before;

    initial begin
        for (int a = 0; a < 65536; a++) begin
            logic [15:0] av;
            av = a[15:0];
            mem[a] = av[7:0] ^ av[15:8];
            shadow[a] = av[7:0] ^ av[15:8];
        end
        i_reset = 1; i_cpu_addr = '0; i_cpu_dat = '0; i_cpu_we = 0; i_cpu_cs = 0;
        i_vga_access = 0; i_vga_addr = '0; i_vga_cs = 0;
        repeat (3) next_cycle();
        i_reset = 0;
        mid_cycle();
        chk("rst_busy", o_cpu_busy, 1'b0);
        chk("rst_cpu_dat", o_cpu_dat, 8'h00);
        chk("rst_max_wait", o_max_wait, 8'h00);
        chk("rst_ram_cs", o_ram_cs, 1'b0);

        // Free bus: write then read back.
        next_cycle(); i_cpu_cs = 1; i_cpu_we = 1; i_cpu_addr = 16'h1005; i_cpu_dat = 8'hA5;
        next_cycle(); i_cpu_cs = 0;
        mid_cycle();
        chk("wr_ram_we", o_ram_we, 1'b1);
        chk("wr_ram_addr", o_ram_addr, 16'h1005);
        chk("wr_ram_dat", o_ram_dat, 8'hA5);
        next_cycle(); mid_cycle();
        chk("wr_ack", o_cpu_ack, 1'b1);
        next_cycle(); i_cpu_cs = 1; i_cpu_we = 0; i_cpu_addr = 16'h1005;
        next_cycle(); i_cpu_cs = 0;
        next_cycle(); mid_cycle();
        chk("rd_ack", o_cpu_ack, 1'b1);
        chk("rd_dat", o_cpu_dat, 8'hA5);

        // VGA slot announced in the strobe cycle defers the CPU by one cycle.
        next_cycle(); i_vga_access = 1; i_vga_addr = 16'h0100;
        i_cpu_cs = 1; i_cpu_we = 1; i_cpu_addr = 16'h2000; i_cpu_dat = 8'h3C;
        next_cycle(); i_vga_access = 0; i_vga_cs = 1; i_cpu_cs = 0;
        mid_cycle();
        chk("vslot_addr", o_ram_addr, 16'h0100);
        chk("vslot_we", o_ram_we, 1'b0);
        next_cycle(); i_vga_cs = 0;
        mid_cycle();
        chk("vslot_cpu_addr", o_ram_addr, 16'h2000);
        chk("vslot_cpu_we", o_ram_we, 1'b1);
        next_cycle(); mid_cycle();
        chk("vslot_ack", o_cpu_ack, 1'b1);
        chk("vslot_max_wait", o_max_wait, 8'h01);

        // Second strobe while busy must vanish.
        next_cycle(); i_cpu_cs = 1; i_cpu_we = 1; i_cpu_addr = 16'h3000; i_cpu_dat = 8'h11;
        next_cycle(); i_cpu_addr = 16'h3001; i_cpu_dat = 8'h22;
        next_cycle(); i_cpu_cs = 0;
        mid_cycle();
        chk("busy_ack", o_cpu_ack, 1'b1);
        next_cycle(); next_cycle(); mid_cycle();
        chk("busy_first_written", mem[16'h3000], 8'h11);
        chk("busy_second_dropped", mem[16'h3001], 8'h31);

        // VGA fetch pattern: 2 owned cycles out of every 8, CPU strobing continuously.
        acks_before = dut_acks;
        for (int i = 0; i < 160; i++) begin
            next_cycle();
            i_vga_access = (i % 8 == 0) || (i % 8 == 1);
            i_vga_cs     = (i % 8 == 1) || (i % 8 == 2);
            i_vga_addr   = 16'h8000 + 16'(i);
            i_cpu_cs     = 1;
            i_cpu_we     = 1'($urandom % 2);
            i_cpu_addr   = 16'h5000 + 16'($urandom % 256);
            i_cpu_dat    = 8'($urandom);
        end
        next_cycle(); i_vga_access = 0; i_vga_cs = 0; i_cpu_cs = 0;
        repeat (4) next_cycle();
        mid_cycle();
        chk("pat_vga_err", o_vga_err, 1'b0);
        chk("pat_min_acks", (dut_acks - acks_before) >= 40, 1'b1);
        chk("pat_ack_total", dut_acks, m_accepts);

        // Unannounced VGA strobe: error flag and deferred CPU issue.
        next_cycle(); i_cpu_cs = 1; i_cpu_we = 0; i_cpu_addr = 16'h1005;
        next_cycle(); i_cpu_cs = 0; i_vga_cs = 1; i_vga_addr = 16'h0200;
        mid_cycle();
        chk("err_vga_addr", o_ram_addr, 16'h0200);
        chk("err_not_yet", o_vga_err, 1'b0);
        next_cycle(); i_vga_cs = 0;
        mid_cycle();
        chk("err_set", o_vga_err, 1'b1);
        chk("err_cpu_issue", o_ram_addr, 16'h1005);
        next_cycle(); mid_cycle();
        chk("err_ack", o_cpu_ack, 1'b1);
        chk("err_rd_dat", o_cpu_dat, 8'hA5);
        next_cycle(); next_cycle(); mid_cycle();
        chk("err_sticky", o_vga_err, 1'b1);

        // Reset on the would-be issue cycle of a queued write.
        acks_before = dut_acks;
        next_cycle(); i_vga_access = 1;
        i_cpu_cs = 1; i_cpu_we = 1; i_cpu_addr = 16'h4000; i_cpu_dat = 8'h77;
        next_cycle(); i_vga_access = 0; i_cpu_cs = 0;
        next_cycle(); i_reset = 1;
        mid_cycle();
        chk("rstq_ram_we", o_ram_we, 1'b0);
        next_cycle(); i_reset = 0;
        mid_cycle();
        chk("rstq_busy", o_cpu_busy, 1'b0);
        chk("rstq_err", o_vga_err, 1'b0);
        next_cycle(); next_cycle(); mid_cycle();
        chk("rstq_no_write", mem[16'h4000], 8'h40);
        chk("rstq_no_ack", dut_acks, acks_before);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
